// File: rtl/spi_shift_engine_if.sv
// -----------------------------------------------------------------------------
// spi_shift_engine_if
//
// Bundles every non-clock signal of the SPI shift engine: the request side
// coming from the register block (start strobe, transmit byte, mode and baud
// fields), the serial pins (SCLK, SS, MOSI, MISO) and the status returned to
// the register block (tip, receive strobe, received byte).
//
// Modports:
//   master : register block / bench side. Drives requests, config and miso_i;
//            observes serial outputs and status.
//   slave  : the shift engine itself.
//
// Signals:
//   send_data_i     start request, sampled every PCLK
//   mosi_data_i     byte to transmit, captured at start
//   mstr_i          master enable
//   cpol_i          clock polarity (SCLK idle level)
//   cpha_i          clock phase (0: sample on odd edges, 1: on even edges)
//   lsbfe_i         1: LSB first, 0: MSB first
//   spi_mode_i      00 run, 01 wait, 10 stop
//   sppr_i, spr_i   baud prescaler / rate selects
//   miso_i          serial input
//   sclk_o          serial clock
//   ss_o            slave select, active low
//   mosi_o          serial output
//   tip_o           transfer in progress
//   receive_data_o  one-cycle pulse, miso_data_o holds a fresh byte
//   miso_data_o     last received byte
// -----------------------------------------------------------------------------
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  send_data_i;
    logic [DATA_WIDTH-1:0] mosi_data_i;
    logic                  mstr_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  lsbfe_i;
    logic [1:0]            spi_mode_i;
    logic [2:0]            sppr_i;
    logic [2:0]            spr_i;
    logic                  miso_i;

    logic                  sclk_o;
    logic                  ss_o;
    logic                  mosi_o;
    logic                  tip_o;
    logic                  receive_data_o;
    logic [DATA_WIDTH-1:0] miso_data_o;

    modport master (
        output send_data_i,
        output mosi_data_i,
        output mstr_i,
        output cpol_i,
        output cpha_i,
        output lsbfe_i,
        output spi_mode_i,
        output sppr_i,
        output spr_i,
        output miso_i,
        input  sclk_o,
        input  ss_o,
        input  mosi_o,
        input  tip_o,
        input  receive_data_o,
        input  miso_data_o
    );

    modport slave (
        input  send_data_i,
        input  mosi_data_i,
        input  mstr_i,
        input  cpol_i,
        input  cpha_i,
        input  lsbfe_i,
        input  spi_mode_i,
        input  sppr_i,
        input  spr_i,
        input  miso_i,
        output sclk_o,
        output ss_o,
        output mosi_o,
        output tip_o,
        output receive_data_o,
        output miso_data_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// Serial back end of the SPI controller. On a start request from the register
// block it latches the configuration and transmit byte, then runs one
// full-duplex transfer in master mode: SS low for a lead half-period,
// 2*DATA_WIDTH SCLK edges spaced one half-period apart, and a trailing
// half-period before SS is released and the received byte is returned with a
// one-cycle receive_data_o strobe.
//
// Half-period H = (sppr+1) * 2^spr PCLK cycles (1..1024).
//
// Ports:
//   PCLK    system clock, all logic on the rising edge
//   PRESET  asynchronous active-high reset
//   bus     spi_shift_engine_if.slave (requests, serial pins, status)
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    spi_shift_engine_if.slave bus
);

    localparam int          EDGES     = 2 * DATA_WIDTH;
    localparam int          EW        = $clog2(EDGES + 1);
    localparam logic [1:0]  MODE_STOP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEAD  = 2'b01,
        XFER  = 2'b10,
        TRAIL = 2'b11
    } state_t;

    // Reload value for the half-period down-counter (H-1).
    function automatic logic [10:0] half_m1(input logic [2:0] pr, input logic [2:0] r);
        logic [10:0] h;
        h = (11'(pr) + 11'd1) << r;
        return h - 11'd1;
    endfunction

    state_t                state_reg, state_next;
    logic [10:0]           cnt_reg, cnt_next;
    logic [EW-1:0]         edge_reg, edge_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;

    // Configuration copies taken at start; the live inputs are ignored
    // until the next transfer.
    logic                  cpol_reg, cpol_next;
    logic                  cpha_reg, cpha_next;
    logic                  lsbfe_reg, lsbfe_next;
    logic [2:0]            sppr_reg, sppr_next;
    logic [2:0]            spr_reg, spr_next;

    logic                  sclk_reg, sclk_next;
    logic                  ss_reg, ss_next;
    logic                  mosi_reg, mosi_next;
    logic                  tip_reg, tip_next;
    logic                  rd_reg, rd_next;
    logic [DATA_WIDTH-1:0] miso_data_reg, miso_data_next;

    logic [10:0]           reload_lat;
    logic [10:0]           reload_in;
    logic [DATA_WIDTH-1:0] shift_msb;
    logic [DATA_WIDTH-1:0] shift_lsb;
    logic                  drive_bit;

    assign reload_lat = half_m1(sppr_reg, spr_reg);
    assign reload_in  = half_m1(bus.sppr_i, bus.spr_i);

    // Shift candidates: MSB-first moves left and inserts the sample at bit 0,
    // LSB-first moves right and inserts the sample at the top bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_msb_in
                assign shift_msb[gi] = bus.miso_i;
            end else begin : g_msb_mv
                assign shift_msb[gi] = shift_reg[gi-1];
            end
            if (gi == DATA_WIDTH - 1) begin : g_lsb_in
                assign shift_lsb[gi] = bus.miso_i;
            end else begin : g_lsb_mv
                assign shift_lsb[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    // The outgoing bit always sits at the end the register shifts out of.
    assign drive_bit = lsbfe_reg ? shift_reg[0] : shift_reg[DATA_WIDTH-1];

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            edge_reg      <= '0;
            shift_reg     <= '0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            lsbfe_reg     <= 1'b0;
            sppr_reg      <= '0;
            spr_reg       <= '0;
            sclk_reg      <= 1'b0;
            ss_reg        <= 1'b1;
            mosi_reg      <= 1'b0;
            tip_reg       <= 1'b0;
            rd_reg        <= 1'b0;
            miso_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            edge_reg      <= edge_next;
            shift_reg     <= shift_next;
            cpol_reg      <= cpol_next;
            cpha_reg      <= cpha_next;
            lsbfe_reg     <= lsbfe_next;
            sppr_reg      <= sppr_next;
            spr_reg       <= spr_next;
            sclk_reg      <= sclk_next;
            ss_reg        <= ss_next;
            mosi_reg      <= mosi_next;
            tip_reg       <= tip_next;
            rd_reg        <= rd_next;
            miso_data_reg <= miso_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    logic          halt;
    logic          tick;
    logic [EW-1:0] edge_num;
    logic          sample_edge;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        edge_next      = edge_reg;
        shift_next     = shift_reg;
        cpol_next      = cpol_reg;
        cpha_next      = cpha_reg;
        lsbfe_next     = lsbfe_reg;
        sppr_next      = sppr_reg;
        spr_next       = spr_reg;
        sclk_next      = sclk_reg;
        ss_next        = ss_reg;
        mosi_next      = mosi_reg;
        tip_next       = tip_reg;
        rd_next        = 1'b0;
        miso_data_next = miso_data_reg;

        // Wait mode (01) deliberately does not appear here.
        halt        = !bus.mstr_i || (bus.spi_mode_i == MODE_STOP);
        tick        = (cnt_reg == 11'd0);
        edge_num    = edge_reg + EW'(1);
        // CPHA=0 samples on odd edges, CPHA=1 on even edges.
        sample_edge = cpha_reg ? !edge_num[0] : edge_num[0];

        case (state_reg)
            IDLE: begin
                sclk_next = bus.cpol_i;
                ss_next   = 1'b1;
                tip_next  = 1'b0;
                if (bus.send_data_i && !halt) begin
                    cpol_next  = bus.cpol_i;
                    cpha_next  = bus.cpha_i;
                    lsbfe_next = bus.lsbfe_i;
                    sppr_next  = bus.sppr_i;
                    spr_next   = bus.spr_i;
                    shift_next = bus.mosi_data_i;
                    cnt_next   = reload_in;
                    edge_next  = '0;
                    ss_next    = 1'b0;
                    tip_next   = 1'b1;
                    state_next = LEAD;
                    // CPHA=0 slaves sample on the first edge, so the first
                    // bit must already be on the line during the lead time.
                    if (!bus.cpha_i) begin
                        mosi_next = bus.lsbfe_i ? bus.mosi_data_i[0]
                                                : bus.mosi_data_i[DATA_WIDTH-1];
                    end
                end
            end

            LEAD, XFER: begin
                if (halt) begin
                    state_next = IDLE;
                    ss_next    = 1'b1;
                    tip_next   = 1'b0;
                    sclk_next  = cpol_reg;
                end else if (tick) begin
                    cnt_next  = reload_lat;
                    edge_next = edge_num;
                    sclk_next = !sclk_reg;
                    if (sample_edge) begin
                        shift_next = lsbfe_reg ? shift_lsb : shift_msb;
                    end else if (edge_num != EW'(EDGES)) begin
                        mosi_next = drive_bit;
                    end
                    state_next = (edge_num == EW'(EDGES)) ? TRAIL : XFER;
                end else begin
                    cnt_next = cnt_reg - 11'd1;
                end
            end

            TRAIL: begin
                if (halt) begin
                    state_next = IDLE;
                    ss_next    = 1'b1;
                    tip_next   = 1'b0;
                    sclk_next  = cpol_reg;
                end else if (tick) begin
                    // Returning to IDLE here forces one idle cycle before
                    // the next start can be accepted.
                    state_next     = IDLE;
                    ss_next        = 1'b1;
                    tip_next       = 1'b0;
                    miso_data_next = shift_reg;
                    rd_next        = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 11'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.sclk_o         = sclk_reg;
    assign bus.ss_o           = ss_reg;
    assign bus.mosi_o         = mosi_reg;
    assign bus.tip_o          = tip_reg;
    assign bus.receive_data_o = rd_reg;
    assign bus.miso_data_o    = miso_data_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
module tb_spi_shift_engine;

    localparam int DW = 8;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    spi_shift_engine_if #(.DATA_WIDTH(DW)) bus ();

    spi_shift_engine #(.DATA_WIDTH(DW)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] last_rx = 8'h00;

    always @(posedge PCLK) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural SPI slave: counts SCLK edges while SS is low, presents
    // its byte on MISO and captures MOSI on the sampling edges.
    // ------------------------------------------------------------------
    logic [7:0] s_byte  = 8'h00;
    logic [7:0] s_rx    = 8'h00;
    logic       s_cpha  = 1'b0;
    logic       s_lsbfe = 1'b0;
    logic       lb      = 1'b1;
    logic       slave_miso = 1'b0;
    logic       s_prev_sclk = 1'b0;
    logic       s_prev_ss   = 1'b1;
    int         s_edges     = 0;

    assign bus.miso_i = lb ? bus.mosi_o : slave_miso;

    always @(negedge PCLK) begin : slave_model
        int e, k, idx;
        logic [7:0] r;
        e = s_edges;
        r = s_rx;
        if (bus.ss_o) begin
            e = 0;
        end else begin
            if (s_prev_ss) r = 8'h00;
            if (bus.sclk_o != s_prev_sclk) begin
                e = e + 1;
                if (((e % 2) == 1) != s_cpha) begin
                    k = (e - 1) / 2;
                    if (k < 8) r[s_lsbfe ? k : 7 - k] = bus.mosi_o;
                end
            end
        end
        if (s_cpha) idx = (e == 0) ? 0 : (e - 1) / 2;
        else        idx = e / 2;
        if (idx > 7) idx = 7;
        s_edges     <= e;
        s_rx        <= r;
        slave_miso  <= s_byte[s_lsbfe ? idx : 7 - idx];
        s_prev_sclk <= bus.sclk_o;
        s_prev_ss   <= bus.ss_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full transfer with timing and data checks against the slave model.
    task automatic run_xfer(input string name,
                            input logic [2:0] sppr, input logic [2:0] spr,
                            input logic cpol, input logic cpha, input logic lsbfe,
                            input logic [7:0] tx, input logic [7:0] sb, input logic loop,
                            input int exp_tip, input logic [7:0] exp_rx,
                            input int extra_at, input int sppr_at);
        int h, total, tip_n, ss_n, rd_n, rd_at, tog_n, tog_bad;
        logic prev;
        logic [7:0] rx_pulse;
        h = exp_tip / 17;
        @(negedge PCLK);
        bus.sppr_i = sppr; bus.spr_i = spr;
        bus.cpol_i = cpol; bus.cpha_i = cpha; bus.lsbfe_i = lsbfe;
        bus.mosi_data_i = tx;
        s_byte = sb; s_cpha = cpha; s_lsbfe = lsbfe; lb = loop;
        @(negedge PCLK);
        @(negedge PCLK);
        chk({name, "_sclk_idle"}, bus.sclk_o, cpol);
        bus.send_data_i = 1'b1;
        @(negedge PCLK);
        prev = bus.sclk_o;
        total = exp_tip + 4;
        tip_n = 0; ss_n = 0; rd_n = 0; rd_at = -1; tog_n = 0; tog_bad = 0;
        rx_pulse = ~exp_rx;
        for (int k = 0; k <= total; k++) begin
            bus.send_data_i = (k == extra_at);
            if (k == sppr_at) bus.sppr_i = sppr + 3'd3;
            if (bus.tip_o) tip_n++;
            if (!bus.ss_o) ss_n++;
            if (bus.receive_data_o) begin
                rd_n++;
                rd_at = k;
                rx_pulse = bus.miso_data_o;
            end
            if (bus.sclk_o != prev) begin
                tog_n++;
                if (k != tog_n * h) tog_bad++;
            end
            prev = bus.sclk_o;
            @(negedge PCLK);
        end
        bus.send_data_i = 1'b0;
        chk({name, "_edges"}, tog_n, 16);
        chk({name, "_edge_timing"}, tog_bad, 0);
        chk({name, "_tip_cycles"}, tip_n, exp_tip);
        chk({name, "_ss_cycles"}, ss_n, exp_tip);
        chk({name, "_rd_pulses"}, rd_n, 1);
        chk({name, "_rd_cycle"}, rd_at, exp_tip);
        chk({name, "_miso_data"}, rx_pulse, exp_rx);
        chk({name, "_mosi_bits"}, s_rx, tx);
        chk({name, "_miso_hold"}, bus.miso_data_o, exp_rx);
        last_rx = exp_rx;
        $display("xfer %s H=%0d tx=%02h rx=%02h slave_saw=%02h tip=%0d",
                 name, h, tx, rx_pulse, s_rx, tip_n);
    endtask

    typedef struct {
        logic [2:0] sppr;
        logic [2:0] spr;
        logic       cpol;
        logic       cpha;
        logic       lsbfe;
        logic [7:0] tx;
        logic [7:0] sb;
        logic       loop;
        int         exp_tip;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, w, cnt_a, cnt_b;
        logic prev;
        logic [2:0] rp, rs;
        logic rc, rh, rl, rloop;
        logic [7:0] rtx, rsb;
        int rh_cyc;

        vecs[0] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1,    17, 8'hA5};
        vecs[1] = '{3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0,   102, 8'hC3};
        vecs[2] = '{3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b1,    17, 8'h81};
        vecs[3] = '{3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 1'b1,    34, 8'h81};
        vecs[4] = '{3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h6D, 1'b0,   136, 8'h6D};
        vecs[5] = '{3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 8'hE1, 8'h2B, 1'b0, 17408, 8'h2B};

        bus.send_data_i = 1'b0; bus.mosi_data_i = 8'h00; bus.mstr_i = 1'b1;
        bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsbfe_i = 1'b0;
        bus.spi_mode_i = 2'b00; bus.sppr_i = 3'd0; bus.spr_i = 3'd0;

        repeat (3) @(negedge PCLK);
        chk("reset_sclk", bus.sclk_o, 1'b0);
        chk("reset_ss", bus.ss_o, 1'b1);
        chk("reset_mosi", bus.mosi_o, 1'b0);
        chk("reset_tip", bus.tip_o, 1'b0);
        chk("reset_rd", bus.receive_data_o, 1'b0);
        chk("reset_miso_data", bus.miso_data_o, 8'h00);
        PRESET = 1'b0;
        $display("reset released at cycle %0d", cyc);

        // Table-driven transfers
        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].sppr, vecs[i].spr, vecs[i].cpol,
                     vecs[i].cpha, vecs[i].lsbfe, vecs[i].tx, vecs[i].sb, vecs[i].loop,
                     vecs[i].exp_tip, vecs[i].exp_rx, -1, -1);
        end

        // Randomised transfers against the arithmetic reference model
        for (int i = 0; i < 8; i++) begin
            rp = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 2));
            rc = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            rloop = 1'($urandom_range(0, 1));
            rtx = 8'($urandom);
            rsb = 8'($urandom);
            rh_cyc = (int'(rp) + 1) * (1 << rs);
            run_xfer($sformatf("rnd%0d", i), rp, rs, rc, rh, rl, rtx, rsb, rloop,
                     17 * rh_cyc, rloop ? rtx : rsb, -1, -1);
        end

        // Abort at SCLK edge 7 via stop mode
        @(negedge PCLK);
        bus.sppr_i = 3'd0; bus.spr_i = 3'd0; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0;
        bus.lsbfe_i = 1'b0; bus.mosi_data_i = 8'h5A; lb = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        bus.send_data_i = 1'b1;
        @(negedge PCLK);
        bus.send_data_i = 1'b0;
        prev = bus.sclk_o; n = 0; w = 0;
        while (n < 7 && w < 100) begin
            @(negedge PCLK);
            if (bus.sclk_o != prev) n++;
            prev = bus.sclk_o;
            w++;
        end
        chk("abort_reach_edge7", n, 7);
        bus.spi_mode_i = 2'b10;
        @(negedge PCLK);
        chk("abort_ss", bus.ss_o, 1'b1);
        chk("abort_tip", bus.tip_o, 1'b0);
        chk("abort_sclk", bus.sclk_o, 1'b0);
        cnt_a = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.receive_data_o) cnt_a++;
            @(negedge PCLK);
        end
        chk("abort_no_rd", cnt_a, 0);
        chk("abort_miso_data_kept", bus.miso_data_o, last_rx);
        $display("abort ss=%0b tip=%0b miso_data=%02h", bus.ss_o, bus.tip_o, bus.miso_data_o);
        bus.spi_mode_i = 2'b00;
        run_xfer("after_abort", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h69, 8'h00, 1'b1,
                 17, 8'h69, -1, -1);

        // Request during a transfer and sppr change mid-transfer are ignored
        run_xfer("ignored_req", 3'd1, 3'd1, 1'b0, 1'b1, 1'b0, 8'hD2, 8'h4E, 1'b0,
                 68, 8'h4E, 5, 10);

        // Start with master disabled
        @(negedge PCLK);
        bus.mstr_i = 1'b0;
        bus.send_data_i = 1'b1;
        @(negedge PCLK);
        bus.send_data_i = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.ss_o) cnt_a++;
            if (bus.tip_o) cnt_b++;
            @(negedge PCLK);
        end
        chk("nomstr_ss_low", cnt_a, 0);
        chk("nomstr_tip", cnt_b, 0);
        $display("nomstr ss_low_cycles=%0d tip_cycles=%0d", cnt_a, cnt_b);
        bus.mstr_i = 1'b1;

        // Asynchronous reset mid-transfer
        @(negedge PCLK);
        bus.sppr_i = 3'd1; bus.spr_i = 3'd0; bus.cpol_i = 1'b1; bus.cpha_i = 1'b1;
        bus.lsbfe_i = 1'b0; bus.mosi_data_i = 8'h77; lb = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        bus.send_data_i = 1'b1;
        @(negedge PCLK);
        bus.send_data_i = 1'b0;
        repeat (10) @(negedge PCLK);
        chk("rst_pre_tip", bus.tip_o, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst_ss", bus.ss_o, 1'b1);
        chk("rst_sclk", bus.sclk_o, 1'b0);
        chk("rst_tip", bus.tip_o, 1'b0);
        chk("rst_miso_data", bus.miso_data_o, 8'h00);
        chk("rst_mosi", bus.mosi_o, 1'b0);
        $display("midreset ss=%0b sclk=%0b tip=%0b miso_data=%02h",
                 bus.ss_o, bus.sclk_o, bus.tip_o, bus.miso_data_o);
        @(negedge PCLK);
        PRESET = 1'b0;
        last_rx = 8'h00;
        run_xfer("after_reset", 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 8'hB4, 8'h1E, 1'b0,
                 34, 8'h1E, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Serial back end of the SPI controller, directly downstream of the APB slave interface. Takes the byte and `send_data` strobe produced by the register block. Generates SCLK from the SPPR/SPR baud fields and drives SS and MOSI in master mode. Shifts MISO in full-duplex and returns the received byte with a one-cycle `receive_data` strobe and a `tip` busy flag to the register block.

## Interface
- DATA_WIDTH, 8, bits per transfer (edges per transfer = 2·DATA_WIDTH)
- PCLK  in  1  system clock; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- send_data_i  in  1  start request, sampled per PCLK
- mosi_data_i  in  DATA_WIDTH  byte to transmit, captured at start
- mstr_i  in  1  master enable
- cpol_i, cpha_i, lsbfe_i  in  1 each  clock polarity, clock phase, LSB-first
- spi_mode_i  in  2  00 run, 01 wait, 10 stop
- sppr_i, spr_i  in  3 each  baud prescaler / rate selects
- miso_i  in  1  serial input
- sclk_o  out  1  serial clock
- ss_o  out  1  slave select, active-low
- mosi_o  out  1  serial output
- tip_o  out  1  transfer in progress
- receive_data_o  out  1  one-cycle pulse, received byte valid
- miso_data_o  out  DATA_WIDTH  last received byte

## Operation
- Reset values: sclk_o=0, ss_o=1, mosi_o=0, tip_o=0, receive_data_o=0, miso_data_o=0, FSM=IDLE.
- Half-period H = (sppr+1)·2^spr PCLK cycles, range 1..1024. Use an 11-bit down-counter. SCLK period = 2H.
- FSM states: IDLE, LEAD, XFER, TRAIL.
- IDLE:
  - sclk_o = registered cpol_i; ss_o=1; tip_o=0.
  - Start when send_data_i=1 and mstr_i=1 and spi_mode_i≠10.
  - On start: latch cpol, cpha, lsbfe, sppr, spr and mosi_data_i into the shift register. Enter LEAD.
- LEAD:
  - ss_o=0, tip_o=1, lasts H cycles.
  - If CPHA=0, the first data bit is driven on mosi_o on entry.
- XFER:
  - 16 SCLK edges (2·DATA_WIDTH), one toggle every H cycles. Edge counter 1..16.
  - CPHA=0: sample miso_i on odd edges; drive the next bit on even edges 2..14.
  - CPHA=1: drive a bit on odd edges; sample on even edges.
  - MSB-first (lsbfe=0): shift left, insert the sample at bit 0, mosi_o = bit 7.
  - LSB-first (lsbfe=1): shift right, insert the sample at bit 7, mosi_o = bit 0.
- TRAIL:
  - ss_o held 0 for H cycles after edge 16. sclk_o is at idle polarity.
  - On exit: ss_o=1, tip_o=0, miso_data_o ← shift register, receive_data_o=1 for one cycle. Return to IDLE.
- Abort: if mstr_i=0 or spi_mode_i=10 in LEAD, XFER or TRAIL, the FSM goes to IDLE on the next edge.
  - ss_o=1, sclk_o=latched cpol.
  - No receive_data_o pulse; miso_data_o unchanged.
- spi_mode_i=01 (wait) does not block or abort a transfer.
- send_data_i while tip_o=1 is ignored and not queued.
- Config inputs changing mid-transfer have no effect; the latched copies are used.
- PRESET mid-transfer: all outputs return to reset values immediately, asynchronously.

## Timing
- Reference point: send_data_i is sampled high at PCLK edge E0.
- E0: LEAD entered; ss_o=0 and tip_o=1 registered at E0.
- SCLK edge n (n=1..16) toggles at E0+n·H.
- Sampling uses the miso_i value present at that PCLK edge.
- E0+17H:
  - ss_o=1, tip_o=0.
  - receive_data_o=1 and miso_data_o valid for exactly one cycle (until E0+17H+1).
- tip_o is high for 17H cycles.
- Earliest next start is the send_data_i sampled at E0+17H+1. The IDLE cycle between transfers is mandatory.

## Test plan
- Basic transfer:
  - Stimulus: sppr=0, spr=0, cpol=0, cpha=0, lsbfe=0, mosi_data=8'hA5, slave loopback miso=mosi.
  - Required: mosi bits 1,0,1,0,0,1,0,1; sclk period 2 PCLK; tip high 17 cycles; receive_data pulse at E0+17; miso_data=8'hA5.
- Slow clock, reversed bit order:
  - Stimulus: sppr=2, spr=1 (H=6), cpol=1, cpha=1, lsbfe=1, mosi_data=8'h3C, slave drives 8'hC3.
  - Required: sclk idles 1, period 12 PCLK; mosi LSB-first 0,0,1,1,1,1,0,0; tip high 102 cycles; miso_data=8'hC3.
- Remaining modes:
  - Stimulus: cpol/cpha = 01 and 10, each with 8'h81 looped back.
  - Required: capture on the correct edge parity; miso_data=8'h81 in both modes.
- Abort:
  - Stimulus: spi_mode→10 at edge 7.
  - Required: ss_o=1 and tip_o=0 one cycle later; no receive_data pulse; miso_data retains its previous value.
  - Stimulus: a later send_data with spi_mode=00.
  - Required: a normal transfer.
- Ignored requests:
  - Stimulus: send_data pulsed at E0+5 during a transfer, and sppr changed mid-transfer.
  - Required: single transfer only; unchanged 17H timing.
  - Stimulus: send_data with mstr=0.
  - Required: ss_o stays 1.
- Reset mid-transfer:
  - Stimulus: PRESET asserted mid-XFER (asynchronous, between clock edges).
  - Required: ss_o=1, sclk_o=0, tip_o=0, miso_data_o=0 immediately.
  - Stimulus: PRESET deasserted, then a new start.
  - Required: completes correctly.
